riscv_fetch_unit: RTL



---
 rtl/riscv_fetch_unit_if.sv | 25 ++
 rtl/riscv_fetch_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit_if.sv
// Fetch-stage bundle: imem request/response channels, redirect input and the IF/ID handshake.
// master = fetch unit, slave = instruction memory / decode / branch side.
interface riscv_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic        ifid_ready;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;

    modport master (
        output imem_req_valid, imem_req_addr, ifid_valid, ifid_instr, ifid_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, ifid_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, ifid_valid, ifid_instr, ifid_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, ifid_ready
    );
endinterface

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: credit-limited sequential imem requests, prefetch queue, redirect flush.
// Optional macro FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_starved counters.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          QDEPTH          = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic               clock,
    input  logic               reset,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_starved,
`endif
    riscv_fetch_unit_if.master bus
);
    localparam int              AW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int              CW       = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0]   QDEPTH_C = CW'(QDEPTH);
    localparam logic [CW-1:0]   MAXOUT_C = CW'(MAX_OUTSTANDING);
    localparam logic [31:0]     NOP      = 32'h0000_0013;

    logic [31:0]   fpc_q, fpc_d, rpc_q, rpc_d;
    logic [CW-1:0] cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [31:0]   qinstr_q [QDEPTH];
    logic [31:0]   qpc_q    [QDEPTH];
    logic [CW:0]   credit;
    logic [31:0]   redir_pc;
    logic          fire, push, pop, rsp_drop;

    // Queue slots plus in-flight requests never exceed the queue size, so a push always has room.
    assign credit   = {1'b0, cnt_q} + {1'b0, out_q};
    assign redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;

    assign bus.imem_req_valid = !reset && !bus.redirect_valid && (out_q < MAXOUT_C)
                                && (credit < {1'b0, QDEPTH_C});
    assign bus.imem_req_addr  = fpc_q;
    assign bus.ifid_valid     = !reset && (cnt_q != '0);
    assign bus.ifid_instr     = bus.ifid_valid ? qinstr_q[rptr_q] : NOP;
    assign bus.ifid_pc        = bus.ifid_valid ? qpc_q[rptr_q] : 32'h0;

    assign fire     = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_drop = (drop_q != '0);
    assign push     = bus.imem_rsp_valid && !rsp_drop && !bus.redirect_valid;
    assign pop      = bus.ifid_valid && bus.ifid_ready && !bus.redirect_valid;

    always_comb begin
        fpc_d  = fpc_q;
        rpc_d  = rpc_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        drop_d = drop_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (bus.redirect_valid) begin
            // Every request still in flight belongs to the old stream, including any already marked.
            fpc_d  = redir_pc;
            rpc_d  = redir_pc;
            cnt_d  = '0;
            wptr_d = '0;
            rptr_d = '0;
            out_d  = out_q - CW'(bus.imem_rsp_valid);
            drop_d = out_q - CW'(bus.imem_rsp_valid);
        end else begin
            if (fire)
                fpc_d = fpc_q + 32'd4;
            out_d = out_q + CW'(fire) - CW'(bus.imem_rsp_valid);
            if (bus.imem_rsp_valid && rsp_drop)
                drop_d = drop_q - CW'(1);
            if (push) begin
                rpc_d  = rpc_q + 32'd4;
                wptr_d = wptr_q + AW'(1);
            end
            if (pop)
                rptr_d = rptr_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fpc_q  <= RESET_PC;
            rpc_q  <= RESET_PC;
            cnt_q  <= '0;
            out_q  <= '0;
            drop_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            fpc_q  <= fpc_d;
            rpc_q  <= rpc_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            drop_q <= drop_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            qinstr_q[wptr_q] <= bus.imem_rsp_data;
            qpc_q[wptr_q]    <= rpc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            assert (!(push && !pop && (cnt_q == QDEPTH_C)));
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_starved_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_starved_q <= '0;
        end else begin
            if (pop)
                perf_fetched_q <= sat_inc(perf_fetched_q);
            if (bus.ifid_ready && !bus.ifid_valid)
                perf_starved_q <= sat_inc(perf_starved_q);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_starved = perf_starved_q;
`endif
endmodule
